// File: rtl/arm_mem_pkg.sv
// Shared definitions for the instruction fetch memory.
//   DEFAULT_DATA_W : default instruction word width
//   NOP_INSTR      : ARM MOV R0,R0, returned on reset and on faulting fetches
//   fsm_state_t    : LOAD / RUN control state encoding
package arm_mem_pkg;

  localparam int DEFAULT_DATA_W = 32;

  localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

  typedef logic [0:0] fsm_state_t;
  localparam fsm_state_t ST_LOAD = 1'b0;
  localparam fsm_state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/instruction_fetch_mem_inst_ram.sv
// inst_ram: DEPTH x DATA_W instruction storage.
//   one write port  : we / waddr / wdata
//   one read port   : re / raddr, registered rdata (updates only when re=1,
//                     otherwise holds its last value)
// No reset on the array or the read register: contents survive reset.
module inst_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instruction_fetch_mem.sv
// instruction_fetch_mem: program-loadable instruction memory with a
// one-cycle-latency fetch port.
//   clk, rst                        : clock, async active-high reset
//   prog_we/prog_addr/prog_data     : program-load writes (LOAD state only)
//   prog_done                       : pulse that moves LOAD -> RUN
//   prog_count, prog_err, running   : load status / FSM state (running = RUN)
//   fetch_req/fetch_addr/stall      : fetch request, byte PC, stall
//   inst_valid/instruction/fetch_fault : fetch result, one cycle after accept
// Handshake: a fetch is accepted on a rising edge where running=1,
// fetch_req=1 and stall=0; its result is visible after that same edge.
// stall=1 freezes all fetch outputs and accepts nothing.
module instruction_fetch_mem
  import arm_mem_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prog_we,
  input  logic [ADDR_W-1:0]        prog_addr,
  input  logic [DATA_W-1:0]        prog_data,
  input  logic                     prog_done,
  output logic [$clog2(DEPTH):0]   prog_count,
  output logic                     prog_err,
  output logic                     running,
  input  logic                     fetch_req,
  input  logic [ADDR_W-1:0]        fetch_addr,
  input  logic                     stall,
  output logic                     inst_valid,
  output logic [DATA_W-1:0]        instruction,
  output logic                     fetch_fault
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  fsm_state_t        state;
  logic              load_ok;
  logic              fetch_ok;
  logic              accept;
  logic              use_nop;
  logic [IDX_W-1:0]  prog_idx;
  logic [IDX_W-1:0]  fetch_idx;
  logic [DATA_W-1:0] ram_rdata;

  assign prog_idx  = prog_addr[IDX_W+1:2];
  assign fetch_idx = fetch_addr[IDX_W+1:2];

  // A load write lands only when aligned and inside the array.
  assign load_ok = (state == ST_LOAD) && prog_we && (prog_addr[1:0] == 2'b00)
                   && ((prog_addr >> 2) < ADDR_W'(DEPTH));

  assign accept   = (state == ST_RUN) && fetch_req && !stall;
  assign fetch_ok = (fetch_addr[1:0] == 2'b00) && ((fetch_addr >> 2) < ADDR_W'(DEPTH));

  inst_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_inst_ram (
    .clk   (clk),
    .we    (load_ok),
    .waddr (prog_idx),
    .wdata (prog_data),
    .re    (accept && fetch_ok),
    .raddr (fetch_idx),
    .rdata (ram_rdata)
  );

  // LOAD -> RUN on prog_done; RUN is left only through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_LOAD;
    else if ((state == ST_LOAD) && prog_done) state <= ST_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prog_count <= '0;
      prog_err   <= 1'b0;
    end else begin
      if (load_ok) prog_count <= prog_count + CNT_W'(1);
      if ((state == ST_RUN) && prog_we) prog_err <= 1'b1;
    end
  end

  // The RAM read register is not reset, so the NOP seen after reset and on
  // faulting fetches is selected by use_nop instead of stored in the RAM path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_valid  <= 1'b0;
      fetch_fault <= 1'b0;
      use_nop     <= 1'b1;
    end else if (!stall) begin
      if (accept) begin
        inst_valid  <= 1'b1;
        fetch_fault <= !fetch_ok;
        use_nop     <= !fetch_ok;
      end else begin
        inst_valid  <= 1'b0;
      end
    end
  end

  assign instruction = use_nop ? DATA_W'(NOP_INSTR) : ram_rdata;
  assign running     = (state == ST_RUN);

endmodule

// File: tb/tb_instruction_fetch_mem.sv
module tb_instruction_fetch_mem;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 64;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'hE1A00000;

  // clock / reset / DUT signals
  logic              clk = 1'b0;
  logic              rst;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              prog_done;
  logic [CNT_W-1:0]  prog_count;
  logic              prog_err;
  logic              running;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              stall;
  logic              inst_valid;
  logic [DATA_W-1:0] instruction;
  logic              fetch_fault;

  always #5 clk = ~clk;

  instruction_fetch_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_done   (prog_done),
    .prog_count  (prog_count),
    .prog_err    (prog_err),
    .running     (running),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .stall       (stall),
    .inst_valid  (inst_valid),
    .instruction (instruction),
    .fetch_fault (fetch_fault)
  );

  // scoreboard state
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [DATA_W-1:0] mem_model [DEPTH];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] prog_words [4];

  // reference model of a fetch result from address alone
  function automatic logic addr_faults(input logic [ADDR_W-1:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  function automatic logic [DATA_W-1:0] fetch_word(input logic [ADDR_W-1:0] a);
    if (addr_faults(a)) return NOP;
    return mem_model[a / 4];
  endfunction

  // advance one rising edge; sample/drive 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    prog_we = 0; prog_addr = '0; prog_data = '0; prog_done = 0;
    fetch_req = 0; fetch_addr = '0; stall = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #1;
    total_cnt++; if (running !== 1'b0) $display("FAIL reset_running got=%0b exp=0", running); else pass_cnt++;
    total_cnt++; if (prog_count !== '0) $display("FAIL reset_count got=%0d exp=0", prog_count); else pass_cnt++;
    total_cnt++; if (prog_err !== 1'b0) $display("FAIL reset_err got=%0b exp=0", prog_err); else pass_cnt++;
    total_cnt++; if (inst_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", inst_valid); else pass_cnt++;
    total_cnt++; if (fetch_fault !== 1'b0) $display("FAIL reset_fault got=%0b exp=0", fetch_fault); else pass_cnt++;
    total_cnt++; if (instruction !== NOP) $display("FAIL reset_instr got=%h exp=%h", instruction, NOP); else pass_cnt++;
    step(); step();
    rst = 0;
  endtask

  task automatic test_load();
    for (int i = 0; i < 4; i++) begin
      prog_we = 1; prog_addr = ADDR_W'(i * 4); prog_data = prog_words[i];
      mem_model[i] = prog_words[i];
      fetch_req = 1; fetch_addr = '0;  // must be ignored in LOAD
      step();
      total_cnt++; if (prog_count !== CNT_W'(i + 1)) $display("FAIL load_count got=%0d exp=%0d", prog_count, i + 1); else pass_cnt++;
      total_cnt++; if (inst_valid !== 1'b0) $display("FAIL load_fetch_ignored got=%0b exp=0", inst_valid); else pass_cnt++;
    end
    // misaligned and out-of-range writes are discarded
    prog_we = 1; prog_addr = 2; prog_data = 32'hDEADBEEF; fetch_req = 0;
    step();
    prog_addr = 256;
    step();
    total_cnt++; if (prog_count !== CNT_W'(4)) $display("FAIL load_bad_discard got=%0d exp=4", prog_count); else pass_cnt++;
    prog_we = 0; prog_done = 1;
    step();
    prog_done = 0;
    total_cnt++; if (running !== 1'b1) $display("FAIL load_running got=%0b exp=1", running); else pass_cnt++;
    total_cnt++; if (prog_count !== CNT_W'(4)) $display("FAIL load_final_count got=%0d exp=4", prog_count); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    fetch_req = 1;
    for (int i = 0; i < 4; i++) begin
      fetch_addr = ADDR_W'(i * 4);
      exp_q.push_back(fetch_word(fetch_addr));
      step();
      total_cnt++; if (inst_valid !== 1'b1) $display("FAIL b2b_valid idx=%0d got=%0b exp=1", i, inst_valid); else pass_cnt++;
      total_cnt++; if (instruction !== exp_q[0]) $display("FAIL b2b_instr idx=%0d got=%h exp=%h", i, instruction, exp_q[0]); else pass_cnt++;
      total_cnt++; if (fetch_fault !== 1'b0) $display("FAIL b2b_fault idx=%0d got=%0b exp=0", i, fetch_fault); else pass_cnt++;
      void'(exp_q.pop_front());
    end
    fetch_req = 0;
    step();
    total_cnt++; if (inst_valid !== 1'b0) $display("FAIL idle_valid got=%0b exp=0", inst_valid); else pass_cnt++;
    total_cnt++; if (instruction !== prog_words[3]) $display("FAIL idle_hold got=%h exp=%h", instruction, prog_words[3]); else pass_cnt++;
  endtask

  task automatic test_fault();
    logic [ADDR_W-1:0] bad [2];
    bad[0] = 6; bad[1] = 256;
    fetch_req = 1;
    for (int i = 0; i < 2; i++) begin
      fetch_addr = bad[i];
      step();
      total_cnt++; if (instruction !== NOP) $display("FAIL fault_instr addr=%0d got=%h exp=%h", bad[i], instruction, NOP); else pass_cnt++;
      total_cnt++; if (fetch_fault !== 1'b1) $display("FAIL fault_flag addr=%0d got=%0b exp=1", bad[i], fetch_fault); else pass_cnt++;
      total_cnt++; if (inst_valid !== 1'b1) $display("FAIL fault_valid addr=%0d got=%0b exp=1", bad[i], inst_valid); else pass_cnt++;
    end
    // stall holds the faulting result
    stall = 1; fetch_addr = 8;
    step();
    total_cnt++; if (fetch_fault !== 1'b1) $display("FAIL fault_stall_hold got=%0b exp=1", fetch_fault); else pass_cnt++;
    stall = 0;
    step();
    total_cnt++; if (fetch_fault !== 1'b0) $display("FAIL fault_clear got=%0b exp=0", fetch_fault); else pass_cnt++;
    total_cnt++; if (instruction !== prog_words[2]) $display("FAIL fault_recover got=%h exp=%h", instruction, prog_words[2]); else pass_cnt++;
    fetch_req = 0;
    step();
  endtask

  task automatic test_stall();
    fetch_req = 1; fetch_addr = 4;
    step();
    total_cnt++; if (instruction !== prog_words[1]) $display("FAIL stall_first got=%h exp=%h", instruction, prog_words[1]); else pass_cnt++;
    stall = 1; fetch_addr = 8;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (instruction !== prog_words[1]) $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i, instruction, prog_words[1]); else pass_cnt++;
      total_cnt++; if (inst_valid !== 1'b1) $display("FAIL stall_valid cyc=%0d got=%0b exp=1", i, inst_valid); else pass_cnt++;
    end
    stall = 0;
    step();
    total_cnt++; if (instruction !== prog_words[2]) $display("FAIL stall_release got=%h exp=%h", instruction, prog_words[2]); else pass_cnt++;
    fetch_req = 0;
    step();
  endtask

  task automatic test_prog_err();
    prog_we = 1; prog_addr = 0; prog_data = 32'hFFFFFFFF;
    step();
    prog_we = 0;
    total_cnt++; if (prog_err !== 1'b1) $display("FAIL prog_err_set got=%0b exp=1", prog_err); else pass_cnt++;
    total_cnt++; if (prog_count !== CNT_W'(4)) $display("FAIL prog_err_count got=%0d exp=4", prog_count); else pass_cnt++;
    fetch_req = 1; fetch_addr = 0;
    step();
    fetch_req = 0;
    total_cnt++; if (instruction !== prog_words[0]) $display("FAIL prog_err_mem got=%h exp=%h", instruction, prog_words[0]); else pass_cnt++;
    step();
    total_cnt++; if (prog_err !== 1'b1) $display("FAIL prog_err_sticky got=%0b exp=1", prog_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    fetch_req = 1; fetch_addr = 4;
    step();
    fetch_addr = 8;
    #2;
    rst = 1;
    #1;
    total_cnt++; if (inst_valid !== 1'b0) $display("FAIL rstmid_valid got=%0b exp=0", inst_valid); else pass_cnt++;
    total_cnt++; if (instruction !== NOP) $display("FAIL rstmid_instr got=%h exp=%h", instruction, NOP); else pass_cnt++;
    total_cnt++; if (running !== 1'b0) $display("FAIL rstmid_running got=%0b exp=0", running); else pass_cnt++;
    total_cnt++; if (prog_err !== 1'b0) $display("FAIL rstmid_err got=%0b exp=0", prog_err); else pass_cnt++;
    total_cnt++; if (prog_count !== '0) $display("FAIL rstmid_count got=%0d exp=0", prog_count); else pass_cnt++;
    step();
    rst = 0;
    step();  // fetch_req still high but in LOAD
    total_cnt++; if (inst_valid !== 1'b0) $display("FAIL rstmid_no_stale got=%0b exp=0", inst_valid); else pass_cnt++;
    fetch_req = 0; prog_done = 1;
    step();
    prog_done = 0;
    total_cnt++; if (running !== 1'b1) $display("FAIL rstmid_rerun got=%0b exp=1", running); else pass_cnt++;
    fetch_req = 1; fetch_addr = 0;
    step();
    fetch_req = 0;
    total_cnt++; if (instruction !== prog_words[0]) $display("FAIL rstmid_retained got=%h exp=%h", instruction, prog_words[0]); else pass_cnt++;
    total_cnt++; if (inst_valid !== 1'b1) $display("FAIL rstmid_valid_after got=%0b exp=1", inst_valid); else pass_cnt++;
  endtask

  task automatic test_random();
    int exp_count;
    logic exp_valid, exp_fault;
    logic [DATA_W-1:0] exp_instr;
    test_reset();
    exp_count = 0;
    // full load with occasional bad writes mixed in
    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        prog_we = 1; prog_data = $urandom();
        prog_addr = ($urandom_range(0, 1) == 0) ? ADDR_W'(i * 4 + $urandom_range(1, 3))
                                                : ADDR_W'($urandom_range(DEPTH, 200) * 4);
        step();
      end
      prog_we = 1; prog_addr = ADDR_W'(i * 4); prog_data = $urandom();
      mem_model[i] = prog_data;
      exp_count++;
      step();
    end
    prog_we = 0;
    total_cnt++; if (prog_count !== CNT_W'(exp_count)) $display("FAIL rand_count got=%0d exp=%0d", prog_count, exp_count); else pass_cnt++;
    prog_done = 1;
    step();
    prog_done = 0;
    exp_valid = 0; exp_fault = 0; exp_instr = NOP;
    for (int c = 0; c < 300; c++) begin
      fetch_req = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) fetch_addr = ADDR_W'($urandom_range(0, 300));
      else fetch_addr = ADDR_W'($urandom_range(0, DEPTH - 1) * 4);
      if (!stall) begin
        if (fetch_req) begin
          exp_valid = 1; exp_instr = fetch_word(fetch_addr); exp_fault = addr_faults(fetch_addr);
        end else begin
          exp_valid = 0;
        end
      end
      step();
      total_cnt++; if (inst_valid !== exp_valid) $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", c, inst_valid, exp_valid); else pass_cnt++;
      total_cnt++; if (instruction !== exp_instr) $display("FAIL rand_instr cyc=%0d got=%h exp=%h", c, instruction, exp_instr); else pass_cnt++;
      if (exp_valid) begin
        total_cnt++; if (fetch_fault !== exp_fault) $display("FAIL rand_fault cyc=%0d got=%0b exp=%0b", c, fetch_fault, exp_fault); else pass_cnt++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    prog_words[0] = 32'hE3A00014;
    prog_words[1] = 32'hE3A01A01;
    prog_words[2] = 32'hE3A02103;
    prog_words[3] = 32'hE0923002;
    test_reset();
    test_load();
    test_back_to_back();
    test_fault();
    test_stall();
    test_prog_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_mem.md
INSTRUCTION_FETCH_MEM -- requirements
Module: instruction_fetch_mem

Interface
REQ-001 Parameter DATA_W, default 32, instruction word width in bits.
REQ-002 Parameter ADDR_W, default 32, byte-address width of fetch and program ports.
REQ-003 Parameter DEPTH, default 64, number of instruction words stored.
REQ-004 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Port prog_we  in  1  program-load write strobe.
REQ-007 Port prog_addr  in  ADDR_W  program-load byte address.
REQ-008 Port prog_data  in  DATA_W  program-load word.
REQ-009 Port prog_done  in  1  single-cycle pulse ending program load.
REQ-010 Port prog_count  out  $clog2(DEPTH)+1  number of accepted load writes.
REQ-011 Port prog_err  out  1  sticky flag for a write attempted in RUN.
REQ-012 Port running  out  1  high while in RUN state.
REQ-013 Port fetch_req  in  1  fetch request from the fetch stage.
REQ-014 Port fetch_addr  in  ADDR_W  fetch byte address (PC).
REQ-015 Port stall  in  1  fetch-stage stall; freezes outputs.
REQ-016 Port inst_valid  out  1  instruction output valid.
REQ-017 Port instruction  out  DATA_W  fetched word.
REQ-018 Port fetch_fault  out  1  fetch was misaligned or out of range.

Function
REQ-019 Two-state FSM SHALL be used: LOAD (entered on reset) and RUN.
REQ-020 LOAD->RUN SHALL occur on the edge where prog_done=1; RUN SHALL persist until reset; prog_done in RUN SHALL be ignored.
REQ-021 In LOAD, prog_we=1 with prog_addr[1:0]==0 and prog_addr[ADDR_W-1:2]<DEPTH SHALL write prog_data to word prog_addr>>2 and increment prog_count by one.
REQ-022 A load write that is misaligned or out of range SHALL be discarded without incrementing prog_count.
REQ-023 prog_we and prog_done in the same LOAD cycle SHALL perform the write, then enter RUN.
REQ-024 prog_we in RUN SHALL not modify memory and SHALL set prog_err, held until reset.
REQ-025 In RUN, fetch_req=1 with stall=0 SHALL be accepted; instruction/inst_valid SHALL update on the next edge (latency 1 cycle).
REQ-026 Accepted aligned in-range fetch SHALL return word fetch_addr>>2 with fetch_fault=0.
REQ-027 Accepted fetch with fetch_addr[1:0]!=0 or word index >=DEPTH SHALL return NOP (0xE1A00000, MOV R0,R0) with fetch_fault=1 and inst_valid=1.
REQ-028 stall=1 SHALL hold instruction, inst_valid and fetch_fault unchanged and SHALL not accept a request.
REQ-029 stall=0 with fetch_req=0 SHALL drive inst_valid=0 next cycle; instruction SHALL hold its last value.
REQ-030 fetch_req in LOAD SHALL be ignored; inst_valid SHALL stay 0.
REQ-031 Back-to-back accepted fetches SHALL sustain one instruction per cycle.
REQ-032 Memory content SHALL be undefined before first load write; reads return stored value only.

Reset
REQ-033 rst=1 SHALL immediately force: FSM=LOAD, prog_count=0, prog_err=0, running=0, inst_valid=0, fetch_fault=0, instruction=0xE1A00000.
REQ-034 Memory array SHALL not be cleared by reset; contents survive reset.
REQ-035 Reset asserted mid-fetch SHALL discard the in-flight fetch; no valid output after release until a new accepted fetch.

Structure
REQ-036 Shared package arm_mem_pkg SHALL hold the NOP constant, the LOAD/RUN state type and default DATA_W.
REQ-037 Storage SHALL be a sub-module inst_ram (one write port, one synchronous read port, DEPTH x DATA_W); control and fault logic in the top.

Verification
REQ-038 Reset, load words 0..3 at byte addr 0,4,8,12 with 0xE3A00014, 0xE3A01A01, 0xE3A02103, 0xE0923002, prog_done -> prog_count=4, running=1 next cycle.
REQ-039 RUN, fetch addr 0,4,8,12 on consecutive cycles, stall=0 -> instruction 0xE3A00014, 0xE3A01A01, 0xE3A02103, 0xE0923002 one cycle later each, inst_valid=1 continuously.
REQ-040 Fetch addr 6, then addr 256 (DEPTH=64) -> instruction=0xE1A00000, fetch_fault=1, inst_valid=1 both cycles.
REQ-041 Fetch addr 4 accepted, stall=1 for 3 cycles with fetch_addr=8 -> instruction stays 0xE3A01A01 for 3 cycles; after stall drops, addr 8 word appears next cycle.
REQ-042 prog_we=1 addr 0 data 0xFFFFFFFF in RUN -> prog_err=1, fetch addr 0 still returns 0xE3A00014.
REQ-043 Assert rst mid-sequence -> outputs per REQ-033 immediately; after new prog_done, fetch addr 0 returns 0xE3A00014 (memory retained).
